// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-digit multiplexed 7-segment scan driver.
//
// Contents:
//   NUM_DIGITS      number of multiplexed digits
//   SEG_OFF/AN_OFF  all-dark segment and anode patterns (active-low)
//   GLYPH_0..F      active-low segment patterns, bit 0 = a .. bit 6 = g
//   digit_idx_t     type of the scanned digit index
//   an_select()     active-low one-hot anode pattern for a digit index
//
// Optional feature macro used by the top: LEADING_ZERO_BLANK_EN.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;  // lower-case b
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;  // lower-case d
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  typedef logic [1:0] digit_idx_t;

  // Active-low anode pattern with only the selected digit driven low.
  function automatic logic [3:0] an_select(input digit_idx_t idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-nibble to 7-segment glyph decoder.
//
// Ports:
//   nibble_i  in  4  hex digit 0..F
//   seg_o     out 7  active-low segments, seg_o[0]=a .. seg_o[6]=g
//
// Digits 10..15 render as A b C d E F.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (nibble_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed common-anode 7-segment scan driver.
//
// Scans one digit per slot of SCAN_PERIOD clocks, decodes the digit's nibble,
// applies a PWM duty of (brightness+1)/8 inside each slot, and latches the
// inputs into shadow registers once per frame (4 slots) so a frame never
// mixes old and new digits.
//
// Parameters:
//   SCAN_PERIOD  clocks per digit slot, multiple of 8 and >= 8
//
// Ports:
//   clk         in   1   system clock
//   rst         in   1   asynchronous active-high reset
//   value       in   16  four hex digits, digit0 = value[3:0] (rightmost)
//   dp_mask     in   4   decimal point request, bit i = digit i
//   brightness  in   3   0 = 1/8 duty .. 7 = full duty
//   an          out  4   active-low anodes, an[i] = digit i
//   seg         out  7   active-low segments, seg[0]=a .. seg[6]=g
//   dp          out  1   active-low decimal point
//   frame_done  out  1   high for the cycle in which the snapshot is taken
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digits 3..1) whose value and dp request are zero along with all higher
// digits. Blanked slots keep their time; the scan does not skip them.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_PERIOD = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic [2:0]  brightness,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  // Slot counter width covers 0..SCAN_PERIOD-1; threshold width covers the
  // full-duty threshold SCAN_PERIOD itself.
  localparam int CNT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int THR_W = $clog2(SCAN_PERIOD + 1);

  localparam logic [CNT_W-1:0] CNT_TC     = CNT_W'(SCAN_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_PRE_TC = CNT_W'(SCAN_PERIOD - 2);
  localparam logic [THR_W-1:0] DUTY_STEP  = THR_W'(SCAN_PERIOD / 8);
  localparam digit_idx_t       LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;

  logic [15:0]      sh_value_q;
  logic [3:0]       sh_dp_q;
  logic [2:0]       sh_bright_q;

  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  // ---------------------------------------------------------------------------
  // Slot timing
  // ---------------------------------------------------------------------------
  logic slot_end;
  logic frame_end;

  assign slot_end  = (cnt_q == CNT_TC);
  assign frame_end = slot_end && (idx_q == LAST_DIGIT);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + digit_idx_t'(1);
    end
  end

  // frame_done is registered one cycle early so that it is high exactly
  // during the terminal cycle of the last slot, the cycle whose closing edge
  // loads the shadow registers.
  assign frame_done_d = (cnt_q == CNT_PRE_TC) && (idx_q == LAST_DIGIT);

  // ---------------------------------------------------------------------------
  // Digit content from the shadow registers
  // ---------------------------------------------------------------------------
  logic [3:0] nibble;
  logic [6:0] glyph;

  assign nibble = sh_value_q[{idx_q, 2'b00} +: 4];

  seg7_decoder u_decoder (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

  // Duty compare: threshold = (brightness+1) * SCAN_PERIOD/8, at most
  // SCAN_PERIOD, which THR_W is sized to hold.
  logic [THR_W-1:0] duty_thr;
  logic [THR_W-1:0] cnt_ext;
  logic             duty_on;

  assign duty_thr = (THR_W'(sh_bright_q) + THR_W'(1)) * DUTY_STEP;
  assign cnt_ext  = THR_W'(cnt_q);
  assign duty_on  = (cnt_ext < duty_thr);

  // ---------------------------------------------------------------------------
  // Leading-zero blanking
  // ---------------------------------------------------------------------------
  logic [3:0] blank_vec;

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every higher digit are zero with no dp
  // request; the chain carries "everything above is blank" downwards.
  assign blank_vec[3] = (sh_value_q[15:12] == 4'h0) && !sh_dp_q[3];
  assign blank_vec[2] = blank_vec[3] && (sh_value_q[11:8] == 4'h0) && !sh_dp_q[2];
  assign blank_vec[1] = blank_vec[2] && (sh_value_q[7:4] == 4'h0) && !sh_dp_q[1];
  assign blank_vec[0] = 1'b0;
`else
  assign blank_vec = 4'b0000;
`endif

  logic digit_lit;
  assign digit_lit = duty_on && !blank_vec[idx_q];

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (digit_lit) begin
      an_d  = an_select(idx_q);
      seg_d = glyph;
      dp_d  = ~sh_dp_q[idx_q];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_value_q   <= '0;
      sh_dp_q      <= '0;
      sh_bright_q  <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
      if (frame_end) begin
        sh_value_q  <= value;
        sh_dp_q     <= dp_mask;
        sh_bright_q <= brightness;
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule
